// File: rtl/spi_word_controller.sv
// -----------------------------------------------------------------------------
// spi_word_controller
//   SPI initiator exchanging one full-duplex WORD_BITS word per CS frame,
//   MSB first, SPI mode 0 (SCK idles low, COPI changes on SCK fall, CIPO
//   captured at the end of the SCK high phase).
//
// Ports:
//   CLK       system clock
//   reset     synchronous active-high reset; aborts any transfer
//   tx_data   word to send, latched on accept
//   tx_valid  send request
//   tx_ready  high while idle; accept = tx_valid && tx_ready
//   rx_data   last received word, updated together with rx_valid
//   rx_valid  one-cycle pulse marking a completed exchange
//   busy      high from the cycle after accept until rx_valid
//   SCK       SPI clock (register driven)
//   CS        chip select, active low (register driven)
//   COPI      controller out (MSB of the transmit shift register)
//   CIPO      peripheral out, sampled raw
// -----------------------------------------------------------------------------
module spi_word_controller #(
    parameter int unsigned WORD_BITS = 64,
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned CS_SETUP  = 2,
    parameter int unsigned CS_HOLD   = 2,
    parameter int unsigned CS_IDLE   = 4
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic [WORD_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [WORD_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 busy,
    output logic                 SCK,
    output logic                 CS,
    output logic                 COPI,
    input  logic                 CIPO
);

    // Phase counter covers the longest of the four timed phases.
    localparam int unsigned MAX_AB = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int unsigned MAX_CD = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
    localparam int unsigned PH_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int unsigned BIT_W  = $clog2(WORD_BITS);

    localparam logic [PH_W-1:0]  DIV_LAST   = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]  SETUP_LAST = PH_W'(CS_SETUP - 1);
    localparam logic [PH_W-1:0]  HOLD_LAST  = PH_W'(CS_HOLD - 1);
    localparam logic [PH_W-1:0]  IDLE_LAST  = PH_W'(CS_IDLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WORD_BITS - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SETUP    = 3'd1;
    localparam logic [2:0] ST_SHIFT_LO = 3'd2;
    localparam logic [2:0] ST_SHIFT_HI = 3'd3;
    localparam logic [2:0] ST_HOLD     = 3'd4;
    localparam logic [2:0] ST_GAP      = 3'd5;

    logic [2:0]           state_q,   state_d;
    logic [PH_W-1:0]      ph_cnt_q,  ph_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WORD_BITS-1:0] tx_sr_q,   tx_sr_d;
    logic [WORD_BITS-1:0] rx_sr_q,   rx_sr_d;
    logic [WORD_BITS-1:0] rx_data_d;
    logic                 sck_d;
    logic                 cs_d;
    logic                 tx_ready_d;
    logic                 rx_valid_d;
    logic                 busy_d;

    // COPI is the transmit shift register MSB, so it is a flop output.
    assign COPI = tx_sr_q[WORD_BITS-1];

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        ph_cnt_d   = ph_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data;
        sck_d      = SCK;
        cs_d       = CS;
        tx_ready_d = tx_ready;
        rx_valid_d = 1'b0;
        busy_d     = busy;

        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    tx_sr_d    = tx_data;
                    cs_d       = 1'b0;
                    bit_cnt_d  = '0;
                    ph_cnt_d   = '0;
                    tx_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_SETUP;
                end
            end

            // SETUP is also the low phase ahead of the first SCK rise.
            ST_SETUP: begin
                if (ph_cnt_q == SETUP_LAST) begin
                    ph_cnt_d = '0;
                    sck_d    = 1'b1;
                    state_d  = ST_SHIFT_HI;
                end else begin
                    ph_cnt_d = ph_cnt_q + PH_W'(1);
                end
            end

            // End of high phase: capture CIPO, drop SCK, present next bit.
            ST_SHIFT_HI: begin
                if (ph_cnt_q == DIV_LAST) begin
                    ph_cnt_d = '0;
                    sck_d    = 1'b0;
                    rx_sr_d  = {rx_sr_q[WORD_BITS-2:0], CIPO};
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = ST_HOLD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        tx_sr_d   = {tx_sr_q[WORD_BITS-2:0], 1'b0};
                        state_d   = ST_SHIFT_LO;
                    end
                end else begin
                    ph_cnt_d = ph_cnt_q + PH_W'(1);
                end
            end

            ST_SHIFT_LO: begin
                if (ph_cnt_q == DIV_LAST) begin
                    ph_cnt_d = '0;
                    sck_d    = 1'b1;
                    state_d  = ST_SHIFT_HI;
                end else begin
                    ph_cnt_d = ph_cnt_q + PH_W'(1);
                end
            end

            // Release CS after the hold time; park COPI low between words.
            ST_HOLD: begin
                if (ph_cnt_q == HOLD_LAST) begin
                    ph_cnt_d = '0;
                    cs_d     = 1'b1;
                    tx_sr_d  = '0;
                    state_d  = ST_GAP;
                end else begin
                    ph_cnt_d = ph_cnt_q + PH_W'(1);
                end
            end

            // Result is published at the end of the CS idle gap.
            ST_GAP: begin
                if (ph_cnt_q == IDLE_LAST) begin
                    ph_cnt_d   = '0;
                    rx_data_d  = rx_sr_q;
                    rx_valid_d = 1'b1;
                    tx_ready_d = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    ph_cnt_d = ph_cnt_q + PH_W'(1);
                end
            end

            default: begin
                ph_cnt_d   = '0;
                sck_d      = 1'b0;
                cs_d       = 1'b1;
                tx_ready_d = 1'b1;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ph_cnt_q  <= '0;
            bit_cnt_q <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data   <= '0;
            SCK       <= 1'b0;
            CS        <= 1'b1;
            tx_ready  <= 1'b1;
            rx_valid  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_cnt_q  <= ph_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_data   <= rx_data_d;
            SCK       <= sck_d;
            CS        <= cs_d;
            tx_ready  <= tx_ready_d;
            rx_valid  <= rx_valid_d;
            busy      <= busy_d;
        end
    end

endmodule
